// File: rtl/match_collector.sv
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// match_collector
//
// Collects the per-frame match flags from the comparator bank. After frame_end,
// matches keep accumulating for a short drain window. One result record per
// frame is then written into a small result FIFO, and cmp_clear is pulsed to
// the comparator bank. A consumer reads the FIFO with a valid/ready handshake.
//
// Optional feature (compile-time macro MATCH_HITCNT_EN):
//   When defined, each record also carries res_hit_cnt. This is the number of
//   in-frame cycles (IN_FRAME..PUSH) in which any match_in bit rose 0->1. The
//   count saturates at 8'hFF. When undefined, the port and the counter do not
//   exist.
//
// Ports:
//   clk           in   1           system clock, rising edge
//   n_rst         in   1           synchronous active-low reset
//   frame_start   in   1           first payload word strobe
//   frame_end     in   1           last payload word strobe
//   match_in      in   NUM_CMP     sticky match flags from comparator bank
//   cmp_clear     out  1           one-cycle clear pulse to comparator bank
//   res_valid     out  1           FIFO head record valid
//   res_ready     in   1           consumer accepts head
//   res_mask      out  NUM_CMP     head: OR of match_in over the frame
//   res_frame_id  out  FRAME_ID_W  head: frame sequence number
//   res_flagged   out  1           head: |res_mask
//   overflow      out  1           sticky: a record was dropped
//   drop_cnt      out  16          saturating dropped-record count
//   res_hit_cnt   out  8           head: rising-match cycle count (option)
//------------------------------------------------------------------------------
module match_collector #(
   parameter int NUM_CMP    = 8,
   parameter int FRAME_ID_W = 16,
   parameter int DEPTH      = 4,
   parameter int DRAIN_CYC  = 2
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  frame_start,
   input  logic                  frame_end,
   input  logic [NUM_CMP-1:0]    match_in,
   output logic                  cmp_clear,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [NUM_CMP-1:0]    res_mask,
   output logic [FRAME_ID_W-1:0] res_frame_id,
   output logic                  res_flagged,
   output logic                  overflow,
   output logic [15:0]           drop_cnt
`ifdef MATCH_HITCNT_EN
   ,
   output logic [7:0]            res_hit_cnt
`endif
);

   localparam int AW  = $clog2(DEPTH);
   localparam int PW  = AW + 1;
   localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_IN_FRAME = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_PUSH     = 2'd3
   } state_t;

   state_t                  state_r, state_s;
   logic [NUM_CMP-1:0]      mask_r, mask_s;
   logic [FRAME_ID_W-1:0]   id_r, id_s;
   logic [FRAME_ID_W-1:0]   frame_cnt_r, frame_cnt_s;
   logic [DCW-1:0]          drain_r, drain_s;
   logic                    push_s;
   logic                    cmp_clear_r;

   logic [NUM_CMP-1:0]      mem_mask_r [DEPTH];
   logic [FRAME_ID_W-1:0]   mem_id_r   [DEPTH];
   logic [PW-1:0]           wr_ptr_r, wr_ptr_s;
   logic [PW-1:0]           rd_ptr_r, rd_ptr_s;
   logic                    full_s, pop_s, wr_en_s, drop_s;
   logic [NUM_CMP-1:0]      rec_mask_s;

   logic                    valid_r, valid_s;
   logic [NUM_CMP-1:0]      head_mask_r, head_mask_s;
   logic [FRAME_ID_W-1:0]   head_id_r, head_id_s;
   logic                    head_flag_r;
   logic                    overflow_r;
   logic [15:0]             drop_cnt_r;

`ifdef MATCH_HITCNT_EN
   logic [NUM_CMP-1:0]      prev_r;
   logic                    rise_s;
   logic [7:0]              hit_r, hit_s, rec_hit_s;
   logic [7:0]              mem_hit_r [DEPTH];
   logic [7:0]              head_hit_r, head_hit_s;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
      logic [7:0] r;
      if (inc && (v != 8'hFF)) begin
         r = v + 8'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction
`endif

   // The record that is written during PUSH still includes the match_in value of the PUSH cycle.
   assign rec_mask_s = mask_r | match_in;

   // FSM next-state logic and per-frame accumulation.
   always_comb begin
      state_s     = state_r;
      mask_s      = mask_r;
      id_s        = id_r;
      frame_cnt_s = frame_cnt_r;
      drain_s     = drain_r;
      push_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (frame_start) begin
               mask_s      = match_in;
               id_s        = frame_cnt_r;
               frame_cnt_s = frame_cnt_r + FRAME_ID_W'(1);
               drain_s     = DCW'(DRAIN_CYC - 1);
               if (!frame_end) begin
                  state_s = ST_IN_FRAME;
               end else if (DRAIN_CYC == 1) begin
                  state_s = ST_PUSH;
               end else begin
                  state_s = ST_DRAIN;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_IN_FRAME: begin
            mask_s = mask_r | match_in;
            if (!frame_end) begin
               state_s = ST_IN_FRAME;
            end else if (DRAIN_CYC == 1) begin
               state_s = ST_PUSH;
            end else begin
               state_s = ST_DRAIN;
               drain_s = DCW'(DRAIN_CYC - 1);
            end
         end
         ST_DRAIN: begin
            // drain_r is the number of DRAIN cycles still to run, including this one.
            mask_s = mask_r | match_in;
            if (drain_r <= DCW'(1)) begin
               drain_s = '0;
               state_s = ST_PUSH;
            end else begin
               drain_s = drain_r - DCW'(1);
            end
         end
         ST_PUSH: begin
            push_s  = 1'b1;
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state, accumulator and clear-pulse registers.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_r     <= ST_IDLE;
         mask_r      <= '0;
         id_r        <= '0;
         frame_cnt_r <= '0;
         drain_r     <= '0;
         cmp_clear_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         mask_r      <= mask_s;
         id_r        <= id_s;
         frame_cnt_r <= frame_cnt_s;
         drain_r     <= drain_s;
         cmp_clear_r <= (state_s == ST_PUSH);
      end
   end

`ifdef MATCH_HITCNT_EN
   assign rise_s    = |(match_in & ~prev_r);
   assign rec_hit_s = sat_inc8(hit_r, rise_s);

   // Rising-match counter: cleared at frame start and counting only inside the frame.
   always_comb begin
      hit_s = hit_r;
      case (state_r)
         ST_IDLE: begin
            if (frame_start) begin
               hit_s = 8'd0;
            end else begin
               hit_s = hit_r;
            end
         end
         ST_IN_FRAME: hit_s = sat_inc8(hit_r, rise_s);
         ST_DRAIN:    hit_s = sat_inc8(hit_r, rise_s);
         ST_PUSH:     hit_s = hit_r;
         default:     hit_s = hit_r;
      endcase
   end

   // Previous-cycle match flags and hit counter registers.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         prev_r <= '0;
         hit_r  <= 8'd0;
      end else begin
         prev_r <= match_in;
         hit_r  <= hit_s;
      end
   end
`endif

   // FIFO control. Pop is evaluated first, so a full FIFO that is popped still accepts the push.
   always_comb begin
      full_s   = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
      pop_s    = valid_r & res_ready;
      wr_en_s  = push_s & (~full_s | pop_s);
      drop_s   = push_s & full_s & ~pop_s;
      wr_ptr_s = wr_ptr_r + PW'(wr_en_s);
      rd_ptr_s = rd_ptr_r + PW'(pop_s);
   end

   // Next head record. It bypasses from the write port when the new record lands in the head slot.
   always_comb begin
      valid_s     = (wr_ptr_s != rd_ptr_s);
      head_mask_s = head_mask_r;
      head_id_s   = head_id_r;
`ifdef MATCH_HITCNT_EN
      head_hit_s  = head_hit_r;
`endif
      if (valid_s) begin
         if (wr_en_s && (wr_ptr_r[AW-1:0] == rd_ptr_s[AW-1:0])) begin
            head_mask_s = rec_mask_s;
            head_id_s   = id_r;
`ifdef MATCH_HITCNT_EN
            head_hit_s  = rec_hit_s;
`endif
         end else begin
            head_mask_s = mem_mask_r[rd_ptr_s[AW-1:0]];
            head_id_s   = mem_id_r[rd_ptr_s[AW-1:0]];
`ifdef MATCH_HITCNT_EN
            head_hit_s  = mem_hit_r[rd_ptr_s[AW-1:0]];
`endif
         end
      end else begin
         head_mask_s = head_mask_r;
      end
   end

   // FIFO storage. It needs no reset because the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_mask_r[wr_ptr_r[AW-1:0]] <= rec_mask_s;
         mem_id_r[wr_ptr_r[AW-1:0]]   <= id_r;
`ifdef MATCH_HITCNT_EN
         mem_hit_r[wr_ptr_r[AW-1:0]]  <= rec_hit_s;
`endif
      end else begin
         mem_mask_r[wr_ptr_r[AW-1:0]] <= mem_mask_r[wr_ptr_r[AW-1:0]];
      end
   end

   // FIFO pointers, registered head outputs and drop statistics.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         valid_r     <= 1'b0;
         head_mask_r <= '0;
         head_id_r   <= '0;
         head_flag_r <= 1'b0;
         overflow_r  <= 1'b0;
         drop_cnt_r  <= 16'd0;
`ifdef MATCH_HITCNT_EN
         head_hit_r  <= 8'd0;
`endif
      end else begin
         wr_ptr_r    <= wr_ptr_s;
         rd_ptr_r    <= rd_ptr_s;
         valid_r     <= valid_s;
         head_mask_r <= head_mask_s;
         head_id_r   <= head_id_s;
         head_flag_r <= |head_mask_s;
`ifdef MATCH_HITCNT_EN
         head_hit_r  <= head_hit_s;
`endif
         if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != 16'hFFFF) begin
               drop_cnt_r <= drop_cnt_r + 16'd1;
            end
         end
      end
   end

   assign cmp_clear    = cmp_clear_r;
   assign res_valid    = valid_r;
   assign res_mask     = head_mask_r;
   assign res_frame_id = head_id_r;
   assign res_flagged  = head_flag_r;
   assign overflow     = overflow_r;
   assign drop_cnt     = drop_cnt_r;
`ifdef MATCH_HITCNT_EN
   assign res_hit_cnt  = head_hit_r;
`endif

endmodule

// File: tb/tb_match_collector.sv
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// tb_match_collector
//
// Scoreboard bench for match_collector. Each frame task pushes the record it
// expects into a queue. A monitor pops that queue and compares the record with
// the FIFO head whenever the head is accepted (res_valid & res_ready). Sideband
// outputs (cmp_clear, overflow, drop_cnt, latency) are checked directly.
//------------------------------------------------------------------------------
module tb_match_collector;

   localparam int NUM_CMP    = 8;
   localparam int FRAME_ID_W = 16;
   localparam int DEPTH      = 4;
   localparam int DRAIN_CYC  = 2;

   logic                  clk = 1'b0;
   logic                  n_rst;
   logic                  frame_start;
   logic                  frame_end;
   logic [NUM_CMP-1:0]    match_in;
   logic                  cmp_clear;
   logic                  res_valid;
   logic                  res_ready;
   logic [NUM_CMP-1:0]    res_mask;
   logic [FRAME_ID_W-1:0] res_frame_id;
   logic                  res_flagged;
   logic                  overflow;
   logic [15:0]           drop_cnt;
`ifdef MATCH_HITCNT_EN
   logic [7:0]            res_hit_cnt;
`endif

   match_collector #(
      .NUM_CMP(NUM_CMP), .FRAME_ID_W(FRAME_ID_W), .DEPTH(DEPTH), .DRAIN_CYC(DRAIN_CYC)
   ) dut (
      .clk(clk), .n_rst(n_rst), .frame_start(frame_start), .frame_end(frame_end),
      .match_in(match_in), .cmp_clear(cmp_clear), .res_valid(res_valid),
      .res_ready(res_ready), .res_mask(res_mask), .res_frame_id(res_frame_id),
      .res_flagged(res_flagged), .overflow(overflow), .drop_cnt(drop_cnt)
`ifdef MATCH_HITCNT_EN
      , .res_hit_cnt(res_hit_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  mask;
      logic [15:0] id;
      logic [7:0]  hit;
   } rec_t;

   rec_t        exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_id;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare every accepted head record against the scoreboard queue
   always @(negedge clk) begin
      if (n_rst === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_record: got id %0h expected none", res_frame_id);
         end else begin
            rec_t r;
            r = exp_q.pop_front();
            check("res_frame_id", {16'd0, res_frame_id}, {16'd0, r.id});
            check("res_mask", {24'd0, res_mask}, {24'd0, r.mask});
            check("res_flagged", {31'd0, res_flagged}, {31'd0, |r.mask});
`ifdef MATCH_HITCNT_EN
            check("res_hit_cnt", {24'd0, res_hit_cnt}, {24'd0, r.hit});
`endif
         end
      end
   end

   function automatic logic [7:0] mval(input int c, input logic [7:0] m1, input int c1,
                                       input logic [7:0] m2, input int c2);
      return ((c >= c1) ? m1 : 8'h00) | ((c >= c2) ? m2 : 8'h00);
   endfunction

   // One frame: start at c=0, end at c=end_off, PUSH expected at end_off+2,
   // and one idle cycle at end_off+3. The match_in value is m1 from c1 onward, ORed with m2 from c2 onward.
   task automatic run_frame(input int end_off, input logic [7:0] m1, input int c1,
                            input logic [7:0] m2, input int c2, input bit exp_push,
                            input bit rdy_pulse, input bit chk_lat);
      rec_t       r;
      logic [7:0] mv;
      logic [7:0] pv;
      int         hits;
      r.mask = 8'h00;
      hits   = 0;
      pv     = 8'h00;
      for (int c = 0; c <= end_off + 2; c++) begin
         mv = mval(c, m1, c1, m2, c2);
         r.mask = r.mask | mv;
         if (c >= 1 && (mv & ~pv) != 8'h00 && hits < 255) hits++;
         pv = mv;
      end
      r.id  = exp_id;
      r.hit = hits[7:0];
      exp_id = exp_id + 16'd1;
      if (exp_push) exp_q.push_back(r);
      for (int c = 0; c <= end_off + 3; c++) begin
         frame_start = (c == 0);
         frame_end   = (c == end_off);
         match_in    = mval(c, m1, c1, m2, c2);
         if (rdy_pulse) res_ready = (c == end_off + 2);
         @(negedge clk);
         check("cmp_clear", {31'd0, cmp_clear}, {31'd0, (c == end_off + 2)});
         if (chk_lat && c == end_off + 2) check("res_valid_early", {31'd0, res_valid}, 32'd0);
         if (chk_lat && c == end_off + 3) check("res_valid_latency", {31'd0, res_valid}, 32'd1);
         @(posedge clk);
         #1;
      end
      frame_start = 1'b0;
      frame_end   = 1'b0;
      match_in    = 8'h00;
      if (rdy_pulse) res_ready = 1'b0;
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      exp_id = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
   endtask

   task automatic drain_wait();
      int k;
      k = 0;
      res_ready = 1'b1;
      while (exp_q.size() != 0 && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d records pending expected 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      check("res_valid_after_drain", {31'd0, res_valid}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_rst       = 1'b0;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      match_in    = 8'h00;
      res_ready   = 1'b1;
      exp_id      = 16'd0;

      // 1: reset state
      do_reset();
      @(negedge clk);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_cmp_clear", {31'd0, cmp_clear}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      @(posedge clk);
      #1;

      // 2: clean frame, latency check
      run_frame(5, 8'h00, 99, 8'h00, 99, 1'b1, 1'b0, 1'b1);
      // 3: late match captured in PUSH, then a match one cycle too late
      run_frame(3, 8'h04, 5, 8'h00, 99, 1'b1, 1'b0, 1'b0);
      run_frame(3, 8'h04, 6, 8'h00, 99, 1'b1, 1'b0, 1'b0);
      // Several match patterns, including start and end in the same cycle
      run_frame(6, 8'h01, 2, 8'h08, 4, 1'b1, 1'b0, 1'b0);
      run_frame(0, 8'h80, 0, 8'h00, 99, 1'b1, 1'b0, 1'b1);
      run_frame(4, 8'h30, 1, 8'h42, 3, 1'b1, 1'b0, 1'b0);
      drain_wait();

      // 6: reset in the middle of a frame
      frame_start = 1'b1;
      match_in    = 8'h10;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      @(posedge clk);
      #1;
      n_rst  = 1'b0;
      exp_id = 16'd0;
      @(posedge clk);
      #1;
      n_rst    = 1'b1;
      match_in = 8'h00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("midrst_cmp_clear", {31'd0, cmp_clear}, 32'd0);
         check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
         @(posedge clk);
         #1;
      end
      run_frame(2, 8'h02, 1, 8'h00, 99, 1'b1, 1'b0, 1'b1);
      drain_wait();

      // 4: overflow with the consumer stalled
      do_reset();
      res_ready = 1'b0;
      for (int f = 0; f < 4; f++) run_frame(2, 8'h00, 99, 8'h00, 99, 1'b1, 1'b0, 1'b0);
      run_frame(2, 8'h01, 0, 8'h00, 99, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("ovf_overflow", {31'd0, overflow}, 32'd1);
      check("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd1);
      check("ovf_res_valid", {31'd0, res_valid}, 32'd1);
      check("ovf_head_id_held", {16'd0, res_frame_id}, 32'd0);
      @(posedge clk);
      #1;
      drain_wait();

      // 5: FIFO full, with a pop in the same cycle as the push
      res_ready = 1'b0;
      for (int f = 0; f < 4; f++) run_frame(2, 8'h00, 99, 8'h00, 99, 1'b1, 1'b0, 1'b0);
      run_frame(2, 8'h20, 1, 8'h00, 99, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check("simul_drop_cnt", {16'd0, drop_cnt}, 32'd1);
      check("simul_overflow", {31'd0, overflow}, 32'd1);
      @(posedge clk);
      #1;
      drain_wait();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
